// File: rtl/hamming_serial_tx.sv
// Serialises a payload word as a train of Hamming(7,4) codewords, nibble 0 first,
// with a per-bit strobe, a frame envelope and a one-cycle completion pulse.
module hamming_serial_tx #(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             tx_pause,
  output logic             tx_sd,
  output logic             tx_frame,
  output logic             tx_strobe,
  output logic             done
);

  localparam int NIBS   = WIDTH / 4;
  localparam int NIB_W  = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_hold;
  logic [BAUD_W-1:0]  r_baud;
  logic [2:0]         r_bit;
  logic [NIB_W-1:0]   r_nib;
  logic               r_done;

  logic               w_xfer;
  logic               w_period_end;
  logic               w_frame_end;
  logic [3:0]         w_nibs [NIBS];
  logic [3:0]         w_nib;
  logic [6:0]         w_code;

  generate
    for (genvar gi = 0; gi < NIBS; gi++) begin : g_nib
      assign w_nibs[gi] = r_hold[gi*4 +: 4];
    end
  endgenerate

  // Codeword bit index 0..6 maps to d0,d1,d2,d3,p1,p2,p3.
  assign w_nib  = w_nibs[r_nib];
  assign w_code = {w_nib[0] ^ w_nib[1] ^ w_nib[2],
                   w_nib[0] ^ w_nib[1] ^ w_nib[3],
                   w_nib[0] ^ w_nib[2] ^ w_nib[3],
                   w_nib};

  assign w_xfer       = in_valid && (r_state == IDLE);
  assign w_period_end = (r_state == SEND) && !tx_pause &&
                        (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_frame_end  = w_period_end && (r_bit == 3'd6) &&
                        (r_nib == NIB_W'(NIBS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_xfer)      w_state_next = SEND;
      SEND:    if (w_frame_end) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
      r_baud <= '0;
      r_bit  <= '0;
      r_nib  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      if (w_xfer) begin
        r_hold <= in_data;
        r_baud <= '0;
        r_bit  <= '0;
        r_nib  <= '0;
      end else if (r_state == SEND && !tx_pause) begin
        if (w_period_end) begin
          r_baud <= '0;
          if (r_bit == 3'd6) begin
            r_bit <= '0;
            r_nib <= (r_nib == NIB_W'(NIBS - 1)) ? '0 : r_nib + NIB_W'(1);
          end else begin
            r_bit <= r_bit + 3'd1;
          end
        end else begin
          r_baud <= r_baud + BAUD_W'(1);
        end
      end
    end
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    tx_frame  = (r_state == SEND);
    tx_sd     = 1'b0;
    tx_strobe = 1'b0;
    done      = r_done;
    if (r_state == SEND) begin
      tx_sd     = w_code[r_bit];
      tx_strobe = !tx_pause && (r_baud == '0);
    end
  end

endmodule

// File: tb/tb_hamming_serial_tx.sv
// Bench for hamming_serial_tx: cycle-level reference model plus frame decoder,
// driven by directed scenarios and a random-word run with random pausing.
module tb_hamming_serial_tx;

  localparam int W         = 32;
  localparam int CPB       = 4;
  localparam int NBITS     = 7 * W / 4;
  localparam int FRAME_CYC = NBITS * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          tx_pause = 1'b0;
  logic          tx_sd, tx_frame, tx_strobe, done;

  int total = 0;
  int bad   = 0;

  hamming_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .tx_pause(tx_pause), .tx_sd(tx_sd),
    .tx_frame(tx_frame), .tx_strobe(tx_strobe), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [NBITS-1:0] encode(input logic [W-1:0] w);
    logic [NBITS-1:0] r;
    logic [3:0] n;
    r = '0;
    for (int k = 0; k < W/4; k++) begin
      n = w[4*k +: 4];
      r[7*k+0] = n[0];
      r[7*k+1] = n[1];
      r[7*k+2] = n[2];
      r[7*k+3] = n[3];
      r[7*k+4] = n[0] ^ n[2] ^ n[3];
      r[7*k+5] = n[0] ^ n[1] ^ n[3];
      r[7*k+6] = n[0] ^ n[1] ^ n[2];
    end
    return r;
  endfunction

  // Reference: a frame is NBITS*CPB unpaused cycles; bit i occupies cycles i*CPB..i*CPB+CPB-1.
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  int               m_cnt  = 0;
  logic [NBITS-1:0] m_bits = '0;
  logic [W-1:0]     sb_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      sb_q.delete();
    end else if (m_busy) begin
      m_done <= 1'b0;
      if (!tx_pause) begin
        if (m_cnt == FRAME_CYC - 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_cnt  <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end else begin
      m_done <= 1'b0;
      if (in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_bits <= encode(in_data);
        sb_q.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] exp_v;
    exp_v = {!m_busy, m_busy, m_busy ? m_bits[m_cnt / CPB] : 1'b0,
             m_busy && !tx_pause && (m_cnt % CPB == 0), m_done};
    chk("cycle rdy/frm/sd/stb/done", {59'd0, in_ready, tx_frame, tx_sd, tx_strobe, done},
        {59'd0, exp_v});
  end

  // Frame monitor and decoder built from the serial pins only.
  logic [NBITS-1:0] cur_bits = '0, last_bits = '0;
  int cur_cyc = 0, cur_strb = 0, last_cyc = 0, last_strb = 0;
  int gap = 0, last_gap = 0, done_cnt = 0;
  logic prev_frame = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] dec;
    logic [2:0]   syn;
    logic [6:0]   cw;
    if (!rst) begin
      cur_bits = '0; cur_cyc = 0; cur_strb = 0; prev_frame = 1'b0; gap = 0;
    end else begin
      if (tx_frame) begin
        if (!prev_frame) last_gap = gap;
        cur_cyc++;
        gap = 0;
      end else begin
        gap++;
      end
      if (tx_strobe) begin
        if (cur_strb < NBITS) cur_bits[cur_strb] = tx_sd;
        cur_strb++;
      end
      if (done) begin
        last_bits = cur_bits; last_cyc = cur_cyc; last_strb = cur_strb;
        done_cnt++;
        syn = 3'b000;
        dec = '0;
        for (int k = 0; k < W/4; k++) begin
          cw = cur_bits[7*k +: 7];
          syn = syn | {cw[0]^cw[1]^cw[2]^cw[6], cw[0]^cw[1]^cw[3]^cw[5], cw[0]^cw[2]^cw[3]^cw[4]};
          dec[4*k +: 4] = cw[3:0];
        end
        chk("decode syndrome", {61'd0, syn}, 64'd0);
        if (sb_q.size() == 0) chk("decode no word queued", 64'd0, 64'd1);
        else chk("decode word", {32'd0, dec}, {32'd0, sb_q.pop_front()});
        cur_bits = '0; cur_cyc = 0; cur_strb = 0;
      end
      prev_frame = tx_frame;
    end
  end

  logic rand_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_en) tx_pause = ($urandom_range(0, 7) == 0);
  end

  task automatic send(input logic [W-1:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!done && n < 3000);
    if (!done) chk({nm, " done timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_strobes(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (cur_strb != k && n < 3000);
    if (cur_strb != k) chk("strobe wait timeout", 64'(cur_strb), 64'(k));
  endtask

  logic [NBITS-1:0] ref_bits;
  int dc;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset outputs", {59'd0, in_ready, tx_frame, tx_sd, tx_strobe, done}, 64'b10000);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 0x0000000B: first codeword 1,1,0,1,0,1,0 then zeros
    send(32'h0000000B);
    wait_done("B");
    chk("B bits", 64'(last_bits), 64'h2B);
    chk("B strobes", 64'(last_strb), 64'd56);
    chk("B frame cycles", 64'(last_cyc), 64'd224);
    chk("B done-cycle outputs", {60'd0, in_ready, tx_frame, tx_sd, done}, 64'b1001);
    @(negedge clk); #1;
    chk("B done single", {63'd0, done}, 64'd0);

    // back-to-back 0x1 then 0xFFFFFFFF
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h00000001;
    @(posedge clk); #1;
    in_data  = 32'hFFFFFFFF;
    wait_done("b2b first");
    chk("b2b first bits", 64'(last_bits), 64'h71);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done("b2b second");
    chk("b2b second bits", 64'(last_bits), 64'hFF_FFFF_FFFF_FFFF);
    chk("b2b gap", 64'(last_gap), 64'd1);

    // 0x12345678 unpaused, then paused 5 cycles inside bit period 10
    send(32'h12345678);
    wait_done("nopause");
    ref_bits = last_bits;
    chk("12345678 first cw", 64'(last_bits[6:0]), 64'h38);
    chk("12345678 cycles", 64'(last_cyc), 64'd224);
    send(32'h12345678);
    wait_strobes(11);
    @(posedge clk); #1;
    tx_pause = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tx_pause = 1'b0;
    wait_done("pause");
    chk("pause bits", 64'(last_bits), 64'(ref_bits));
    chk("pause cycles", 64'(last_cyc), 64'd229);
    chk("pause strobes", 64'(last_strb), 64'd56);

    // reset during bit period 20
    send(32'hFFFFFFFF);
    wait_strobes(21);
    dc = done_cnt;
    rst = 1'b0;
    #1;
    chk("midframe reset outputs", {59'd0, in_ready, tx_frame, tx_sd, tx_strobe, done}, 64'b10000);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("no done after abort", 64'(done_cnt), 64'(dc));
    send(32'h0000000B);
    wait_done("after reset");
    chk("after reset bits", 64'(last_bits), 64'h2B);
    chk("after reset strobes", 64'(last_strb), 64'd56);

    // input changes during SEND are ignored
    send(32'h00000000);
    repeat (20) @(posedge clk);
    #1;
    in_data  = 32'hDEADBEEF;
    in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done("ignore");
    chk("ignore bits", 64'(last_bits), 64'd0);

    // random words with random pause
    rand_en = 1'b1;
    for (int i = 0; i < 250; i++) begin
      send($urandom);
      wait_done("random");
    end
    rand_en = 1'b0;
    @(posedge clk); #2;
    tx_pause = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
